wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges a no-backpressure ALU result stream and a buffered LSU stream
// onto a single registered register-file write port, with starvation guard and forwarding.
module wb_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        write_en,
    output logic [4:0]  rd,
    output logic [31:0] write_data,
    output logic        alu_stall,
    input  logic [4:0]  q_rs,
    output logic        q_hit,
    output logic [31:0] q_data,
    output logic [1:0]  pend_cnt,
    output logic        err
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SumW = PtrW + 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned AgeW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]      buf_rd_q   [DEPTH];
    logic [31:0]     buf_data_q [DEPTH];
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [AgeW-1:0] age_q, age_d;
    logic            stall_q, stall_d;
    logic            err_q, err_d;
    logic            we_q, we_d;
    logic [4:0]      rd_q, rd_d;
    logic [31:0]     wdata_q, wdata_d;

    logic head_vld, lsu_acc, lsu_live, alu_req, pop, push, bypass;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (32'(p) == DEPTH - 1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign lsu_ready = !rst && (32'(cnt_q) < DEPTH);
    assign head_vld  = (cnt_q != '0);
    assign lsu_acc   = lsu_valid && lsu_ready;
    assign lsu_live  = lsu_acc && (lsu_rd != 5'd0);
    // ALU results presented during a stall are dropped, never arbitrated.
    assign alu_req   = alu_valid && (alu_rd != 5'd0) && !stall_q;
    assign push      = lsu_live && !bypass;

    always_comb begin
        pop     = 1'b0;
        bypass  = 1'b0;
        we_d    = 1'b0;
        rd_d    = 5'd0;
        wdata_d = 32'd0;
        if (stall_q && head_vld) begin
            pop     = 1'b1;
            we_d    = 1'b1;
            rd_d    = buf_rd_q[head_q];
            wdata_d = buf_data_q[head_q];
        end else if (alu_req) begin
            we_d    = 1'b1;
            rd_d    = alu_rd;
            wdata_d = alu_data;
        end else if (head_vld) begin
            pop     = 1'b1;
            we_d    = 1'b1;
            rd_d    = buf_rd_q[head_q];
            wdata_d = buf_data_q[head_q];
        end else if (lsu_live) begin
            bypass  = 1'b1;
            we_d    = 1'b1;
            rd_d    = lsu_rd;
            wdata_d = lsu_data;
        end
    end

    always_comb begin
        head_d = pop ? ptr_inc(head_q) : head_q;
        tail_d = push ? ptr_inc(tail_q) : tail_q;
        cnt_d  = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
        age_d = age_q;
        if (!head_vld || pop) begin
            age_d = '0;
        end else if (32'(age_q) < STARVE_LIMIT) begin
            age_d = age_q + 1'b1;
        end
        // Stall lands the cycle after the head has lost STARVE_LIMIT times in a row.
        stall_d = head_vld && !pop && (32'(age_q) >= STARVE_LIMIT - 1);
        err_d   = err_q || (stall_q && alu_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            age_q   <= '0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= 5'd0;
            wdata_q <= 32'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            age_q   <= age_d;
            stall_q <= stall_d;
            err_q   <= err_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
        end
    end

    // Payload storage needs no reset: every read is qualified by cnt_q.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            buf_rd_q[tail_q]   <= lsu_rd;
            buf_data_q[tail_q] <= lsu_data;
        end
    end

    // Walk oldest to youngest so the last match found is the youngest.
    always_comb begin
        logic [SumW-1:0] sum;
        q_hit  = 1'b0;
        q_data = 32'd0;
        sum    = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            sum = {1'b0, head_q} + SumW'(k);
            if (32'(sum) >= DEPTH) begin
                sum = sum - SumW'(DEPTH);
            end
            if ((32'(cnt_q) > k) && (q_rs != 5'd0) && (buf_rd_q[sum[PtrW-1:0]] == q_rs)) begin
                q_hit  = 1'b1;
                q_data = buf_data_q[sum[PtrW-1:0]];
            end
        end
    end

    assign write_en   = we_q;
    assign rd         = rd_q;
    assign write_data = wdata_q;
    assign alu_stall  = stall_q;
    assign err        = err_q;
    assign pend_cnt   = 2'(cnt_q);

endmodule
